// File: rtl/interp_fd_stream.sv
// Streaming polyphase interpolator: a 4-tap history is mixed by a per-phase coefficient
// table, and each accepted sample (once the history is full) emits NPH output phases.
module interp_fd_stream #(
  parameter int DW  = 14,
  parameter int CW  = 12,
  parameter int CSH = 10,
  parameter int NPH = 4
) (
  input  logic                       clk325kHz_d1,
  input  logic                       rst,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(NPH)-1:0]     out_phase,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       coef_we,
  input  logic [$clog2(NPH)+1:0]     coef_addr,
  input  logic [CW-1:0]              coef_wdata,
  input  logic                       flush
);
  localparam int PW = $clog2(NPH);
  localparam int AW = DW + CW + 2;
  localparam logic signed [AW-1:0] HALF  = AW'(1) <<< (CSH - 1);
  localparam logic signed [AW-1:0] SMAX  = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN  = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [CW-1:0] UNITY = CW'(1) <<< CSH;

  typedef enum logic {FILL, EMIT} state_t;

  state_t                state, state_nx;
  logic signed [DW-1:0]  hist [4];
  logic signed [CW-1:0]  coef [NPH][4];
  logic [2:0]            fill, fill_nx;
  logic [PW:0]           ph_cnt;
  logic [PW-1:0]         ph_idx, wr_ph;
  logic                  accept, load, last_xfer;
  logic signed [AW-1:0]  acc, rnd;
  logic signed [DW-1:0]  sat;

  assign ph_idx = ph_cnt[PW-1:0];
  assign wr_ph  = coef_addr[PW+1:2];

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    last_xfer = out_valid && out_ready && (out_phase == PW'(NPH - 1));
    fill_nx   = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    unique case (state)
      FILL: in_ready = 1'b1;
      EMIT: begin
        // Ready only while the final phase leaves, so the next sample lands back-to-back.
        in_ready = last_xfer;
        load     = (ph_cnt != (PW+1)'(NPH)) && (!out_valid || out_ready);
        if (last_xfer) state_nx = FILL;
      end
      default: ;
    endcase
    accept = in_valid && in_ready && !flush;
    if (accept && fill_nx == 3'd4) state_nx = EMIT;
    if (flush) state_nx = FILL;
  end

  always_comb begin
    acc = '0;
    for (int t = 0; t < 4; t++)
      acc = acc + AW'(hist[t]) * AW'(coef[ph_idx][t]);
    rnd = (acc + HALF) >>> CSH;
    if (rnd > SMAX)      sat = {1'b0, {(DW-1){1'b1}}};
    else if (rnd < SMIN) sat = {1'b1, {(DW-1){1'b0}}};
    else                 sat = rnd[DW-1:0];
  end

  always_ff @(posedge clk325kHz_d1 or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      fill      <= '0;
      ph_cnt    <= '0;
      out_data  <= '0;
      out_phase <= '0;
      out_valid <= 1'b0;
      for (int t = 0; t < 4; t++) hist[t] <= '0;
    end else begin
      state <= state_nx;
      if (flush) begin
        fill      <= '0;
        ph_cnt    <= '0;
        out_valid <= 1'b0;
      end else begin
        if (accept) begin
          hist[0] <= hist[1];
          hist[1] <= hist[2];
          hist[2] <= hist[3];
          hist[3] <= in_data;
          fill    <= fill_nx;
        end
        if (load) begin
          out_data  <= sat;
          out_phase <= ph_idx;
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
        if (accept)    ph_cnt <= '0;
        else if (load) ph_cnt <= ph_cnt + 1'b1;
      end
    end
  end

  // Table survives flush; only reset restores the pass-through taps.
  always_ff @(posedge clk325kHz_d1 or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NPH; p++)
        for (int t = 0; t < 4; t++)
          coef[p][t] <= (t == 1) ? UNITY : '0;
    end else if (coef_we && int'(wr_ph) < NPH) begin
      coef[wr_ph][coef_addr[1:0]] <= coef_wdata;
    end
  end
endmodule

// File: tb/tb_interp_fd_stream.sv
// Bench for interp_fd_stream: directed scenarios plus randomized traffic checked against a
// transaction-level model (expected-output queue per accepted sample).
module tb_interp_fd_stream;
  localparam int DW = 14, CW = 12, CSH = 10, NPH = 4;
  localparam int PW = $clog2(NPH);

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, out_valid, out_ready, coef_we, flush;
  logic [DW-1:0]   in_data, out_data;
  logic [PW-1:0]   out_phase;
  logic [PW+1:0]   coef_addr;
  logic [CW-1:0]   coef_wdata;

  interp_fd_stream #(.DW(DW), .CW(CW), .CSH(CSH), .NPH(NPH)) dut (
    .clk325kHz_d1(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_phase(out_phase),
    .out_valid(out_valid), .out_ready(out_ready), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .flush(flush));

  always #5 clk = ~clk;

  typedef struct { int d; int p; } res_t;

  int   checks = 0, errors = 0;
  int   mcoef [NPH][4];
  int   mhist [4];
  int   mfill;
  res_t q[$];
  res_t log_q[$];
  bit   prev_hold, prev_acc;
  int   prev_d, prev_p;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_phase(input int p);
    longint s = 0;
    for (int t = 0; t < 4; t++) s += longint'(mcoef[p][t]) * longint'(mhist[t]);
    s = (s + (longint'(1) << (CSH - 1))) >>> CSH;
    if (s > longint'(2**(DW-1) - 1)) s = 2**(DW-1) - 1;
    else if (s < -longint'(2**(DW-1))) s = -(2**(DW-1));
    return int'(s);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NPH; p++)
      for (int t = 0; t < 4; t++) mcoef[p][t] = (t == 1) ? (1 << CSH) : 0;
    for (int t = 0; t < 4; t++) mhist[t] = 0;
    mfill = 0;
    q.delete();
  endtask

  // Compare process: inputs are stable here and describe the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_phase", out_phase, 0);
      model_reset();
      prev_hold = 1'b0;
      prev_acc  = 1'b0;
    end else begin
      chk("in_ready", in_ready,
          (q.size() == 0) || (q.size() == 1 && out_valid && out_ready));
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", int'($signed(out_data)), prev_d);
        chk("hold_phase", out_phase, prev_p);
      end
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_valid", out_valid, 0);
        else begin
          chk("out_data", int'($signed(out_data)), q[0].d);
          chk("out_phase", out_phase, q[0].p);
        end
      end else if (q.size() > 0 && !prev_acc) begin
        chk("late_valid", out_valid, 1);
      end
      prev_hold = out_valid && !out_ready && !flush;
      prev_d    = int'($signed(out_data));
      prev_p    = int'(out_phase);
      prev_acc  = 1'b0;
      if (flush) begin
        q.delete();
        mfill = 0;
      end else begin
        if (out_valid && out_ready) begin
          if (q.size() > 0) void'(q.pop_front());
          log_q.push_back('{int'($signed(out_data)), int'(out_phase)});
        end
        if (in_valid && in_ready) begin
          for (int t = 0; t < 3; t++) mhist[t] = mhist[t+1];
          mhist[3] = int'($signed(in_data));
          if (mfill < 4) mfill++;
          prev_acc = 1'b1;
          if (mfill == 4)
            for (int p = 0; p < NPH; p++) q.push_back('{model_phase(p), p});
        end
      end
      if (coef_we && int'(coef_addr[PW+1:2]) < NPH)
        mcoef[coef_addr[PW+1:2]][coef_addr[1:0]] = int'($signed(coef_wdata));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = v[DW-1:0];
    for (int n = 0; n < 50 && !done; n++) begin
      done = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", done, 1);
  endtask

  task automatic wcoef(input int p, input int t, input int v);
    coef_we    = 1'b1;
    coef_addr  = {p[PW-1:0], t[1:0]};
    coef_wdata = v[CW-1:0];
    tick();
    coef_we = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; flush = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Pass-through table, ramp input; checks first-phase latency.
    out_ready = 1'b1;
    log_q.delete();
    send(0); send(100); send(200);
    send(300);
    chk("lat_e0_valid", out_valid, 0);
    tick();
    chk("lat_e1_valid", out_valid, 1);
    chk("lat_e1_data", int'($signed(out_data)), 100);
    chk("lat_e1_phase", out_phase, 0);
    repeat (8) tick();
    chk("ramp_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("ramp_data", log_q[i].d, 100);
      chk("ramp_phase", log_q[i].p, i);
    end

    // Half-band style taps on phase 2, constant input.
    wcoef(2, 0, -67); wcoef(2, 1, 579); wcoef(2, 2, 579); wcoef(2, 3, -67);
    do_flush();
    log_q.delete();
    repeat (4) send(1000);
    repeat (8) tick();
    chk("const_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) chk("const_data", log_q[i].d, 1000);

    // Saturation on phase 1, both rails.
    for (int t = 0; t < 4; t++) wcoef(1, t, 2047);
    do_flush();
    log_q.delete();
    repeat (4) send(8191);
    repeat (8) tick();
    if (log_q.size() > 1) chk("sat_pos", log_q[1].d, 8191);
    else chk("sat_pos_count", log_q.size(), 4);
    do_flush();
    log_q.delete();
    repeat (4) send(-8192);
    repeat (8) tick();
    if (log_q.size() > 1) chk("sat_neg", log_q[1].d, -8192);
    else chk("sat_neg_count", log_q.size(), 4);

    // Backpressure while phase 1 is presented.
    do_flush();
    log_q.delete();
    send(10); send(20); send(30); send(40);
    tick(); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_phase", out_phase, 1);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    repeat (8) tick();
    chk("bp_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) chk("bp_order", log_q[i].p, i);
    if (log_q.size() > 1) chk("bp_p1_data", log_q[1].d, 200);

    // Reset mid-emission: nothing partial afterwards, full refill needed.
    do_flush();
    send(1); send(2); send(3); send(4);
    repeat (3) tick();
    chk("pre_rst_phase", out_phase, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_valid", out_valid, 0);
    log_q.delete();
    send(5); send(6); send(7);
    repeat (6) tick();
    chk("rst_refill_none", log_q.size(), 0);
    send(8);
    repeat (8) tick();
    chk("rst_refill_count", log_q.size(), 4);
    if (log_q.size() > 0) chk("rst_table_pass", log_q[0].d, 6);

    // Flush beats a same-edge accept; table contents survive flush.
    wcoef(0, 1, 512);
    send(1); send(2);
    flush = 1'b1; in_valid = 1'b1; in_data = DW'(99);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    log_q.delete();
    send(40); send(80); send(120);
    repeat (6) tick();
    chk("flush_no_emit", log_q.size(), 0);
    send(160);
    repeat (8) tick();
    chk("flush_count", log_q.size(), 4);
    if (log_q.size() > 1) begin
      chk("flush_table_p0", log_q[0].d, 40);
      chk("flush_table_p1", log_q[1].d, 80);
    end

    // Randomized traffic, all checked by the compare process.
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom % 2) == 0;
      in_data   = ($urandom % 2) ? DW'($urandom) : DW'($urandom_range(0, 400) - 200);
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 150) == 0;
      coef_we   = 1'b0;
      if (q.size() == 0 && ($urandom % 6) == 0) begin
        in_valid   = 1'b0;
        flush      = 1'b0;
        coef_we    = 1'b1;
        coef_addr  = (PW+2)'($urandom);
        coef_wdata = CW'($urandom_range(0, 2047) - 1024);
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    repeat (12) tick();
    chk("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/interp_fd_stream.md
INTERP_FD_STREAM -- requirements
Module: interp_fd_stream

Interface
REQ-001 SHALL have parameter DW, default 14, meaning signed sample width.
REQ-002 SHALL have parameter CW, default 12, meaning signed coefficient width.
REQ-003 SHALL have parameter CSH, default 10, meaning coefficient fraction bits (unity = 2^CSH).
REQ-004 SHALL have parameter NPH, default 4, range 2..16, meaning output phases per input sample.
REQ-005 SHALL have port clk325kHz_d1, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-007 SHALL have port in_data, input, DW, meaning signed input sample.
REQ-008 SHALL have port in_valid, input, 1, and port in_ready, output, 1; a sample is accepted on an edge where both are 1.
REQ-009 SHALL have port out_data, output, DW, meaning signed interpolated sample.
REQ-010 SHALL have port out_phase, output, clog2(NPH), meaning the phase index of out_data.
REQ-011 SHALL have port out_valid, output, 1, and port out_ready, input, 1; a result transfers on an edge where both are 1.
REQ-012 SHALL have ports coef_we (1), coef_addr (clog2(NPH)+2, {phase,tap}), coef_wdata (CW), all inputs, for table writes.
REQ-013 SHALL have port flush, input, 1, meaning synchronous pipeline clear.

Function
REQ-014 SHALL hold a 4-deep sample history x0 (oldest)..x3 (newest), shifted on every accepted sample.
REQ-015 SHALL keep a fill counter 0..4; emission begins only on the accept that makes the count 4.
REQ-016 SHALL use FSM states FILL, EMIT: FILL -> EMIT on the filling/any later accept; EMIT -> FILL after phase NPH-1 transfers.
REQ-017 SHALL drive in_ready=1 in FILL and in EMIT only while phase NPH-1 sits in the output register being transferred (back-to-back accept).
REQ-018 SHALL compute phase p as y = sum over t of c[p][t]*x_t, full precision width DW+CW+2.
REQ-019 SHALL round by adding 2^(CSH-1), arithmetic-shift right by CSH, then saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-020 SHALL load the output register when it is empty or transferring; the phase counter increments on each load.
REQ-021 SHALL give latency: accept on edge E0 -> phase 0 valid after E1; with out_ready=1, phase p valid after E(1+p).
REQ-022 SHALL hold out_data, out_phase and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL write coef_wdata to c[phase][tap] on the edge where coef_we=1; a same-edge read of that entry uses the old value.
REQ-024 SHALL ignore coef_we when the addressed phase is >= NPH.
REQ-025 SHALL, on flush=1, clear fill count, phase counter and out_valid, go to FILL, and leave the table unchanged; flush has priority over a same-edge accept.

Reset
REQ-026 SHALL, while rst=1, force FILL, fill count 0, phase 0, history 0, out_data 0, out_phase 0, out_valid 0.
REQ-027 SHALL drive in_ready=1 as soon as rst is deasserted.
REQ-028 SHALL reset the table to pass-through: c[p][1]=2^CSH, all other taps 0, for every p.
REQ-029 SHALL abandon any emission in progress when rst asserts mid-operation; no partial phases appear after release.

Verification
REQ-030 Reset table, out_ready=1, input 0,100,200,300 -> phases 0..3 each out_data=100, out_phase=0,1,2,3, first valid after E1 of 4th accept.
REQ-031 Write phase 2 taps -67,579,579,-67, constant input 1000 x4 -> phase 2 out_data=1000; phases 0,1,3 = 1000.
REQ-032 All taps of phase 1 = 2047, input 8191 x4 -> phase 1 out_data=8191 (saturated); input -8192 x4 -> -8192.
REQ-033 out_ready low for 3 cycles during phase 1 -> phase 1 data held stable, in_ready=0, no phase lost or duplicated.
REQ-034 rst pulse during phase 2 of emission -> out_valid=0 next cycle, 4 new inputs required before any output.
REQ-035 flush with in_valid=1 on the same edge -> sample not accepted, fill count 0, table values survive.
